// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl
// ----------------------------------------------------------------------------
// Drives a mux-scan chain through test sessions. Each session applies a stream
// of patterns. For each pattern the controller shifts the stimulus into the
// chain, captures one functional cycle, and compares the result. The unload of
// pattern n-1 is overlapped with the load of pattern n. The final pattern is
// followed by a dedicated UNLOAD phase.
//
// Pattern handshake: the controller raises pat_ready only in LOAD. A pattern is
// transferred on any rising clk edge where pat_valid && pat_ready. pat_ready is
// registered and does not depend on pat_valid. The source may hold pat_valid low
// for as long as it likes; the controller waits in LOAD with the DUT frozen.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 one-cycle session request (honoured in IDLE/DONE)
//   pat_valid/pat_ready   pattern handshake
//   pat_stim, pat_pi      scan load value (bit i -> flop i), primary inputs
//   pat_exp, pat_exp_po   expected captured chain / primary outputs
//   pat_last              final pattern of the session
//   scan_en, scan_in      DUT scan enable (1 = shift) and serial data in
//   dut_ce, dut_pi        DUT flop clock-enable and primary inputs
//   scan_out, dut_po      chain tail Q and DUT primary outputs
//   busy, done            session active / session complete (held)
//   fail_count            failing patterns (saturating)
//   first_fail            index of first failing pattern, 0xFFFF if none
//   pat_count             patterns captured this session (saturating)
//   state_dbg             current FSM state encoding
// ----------------------------------------------------------------------------
module scan_test_ctrl #(
    parameter int CHAIN_LEN = 2,
    parameter int NPI       = 1,
    parameter int NPO       = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_stim,
    input  logic [NPI-1:0]       pat_pi,
    input  logic [CHAIN_LEN-1:0] pat_exp,
    input  logic [NPO-1:0]       pat_exp_po,
    input  logic                 pat_last,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 dut_ce,
    output logic [NPI-1:0]       dut_pi,
    input  logic                 scan_out,
    input  logic [NPO-1:0]       dut_po,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          fail_count,
    output logic [15:0]          first_fail,
    output logic [15:0]          pat_count,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_UNLOAD  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int CW = $clog2(CHAIN_LEN + 1);

    state_t               state;
    logic [CW-1:0]        k;
    // Stimulus and expected values are kept in left-shifting registers so the
    // bit for the current shift cycle is always at the MSB.
    logic [CHAIN_LEN-1:0] stim_sh;
    logic [CHAIN_LEN-1:0] exp_sh;
    logic [CHAIN_LEN-1:0] cur_exp;
    logic [NPO-1:0]       cur_exp_po;
    logic                 cur_last;
    // have_prev: a captured pattern is sitting in the chain awaiting unload.
    // pend_fail/pend_idx: mismatch accumulator and index for that pattern.
    logic                 have_prev;
    logic                 pend_fail;
    logic [15:0]          pend_idx;

    logic                 k_last;
    logic                 bit_mis;
    logic                 shifting;
    logic                 finish_fail;

    assign state_dbg   = state;
    assign k_last      = (k == CW'(CHAIN_LEN - 1));
    assign shifting    = (state == S_SHIFT) || (state == S_UNLOAD);
    assign bit_mis     = have_prev && (scan_out != exp_sh[CHAIN_LEN-1]);
    // The chain comparison of the pending pattern ends on the last shift cycle.
    assign finish_fail = shifting && k_last && have_prev && (pend_fail || bit_mis);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            k          <= '0;
            stim_sh    <= '0;
            exp_sh     <= '0;
            cur_exp    <= '0;
            cur_exp_po <= '0;
            cur_last   <= 1'b0;
            have_prev  <= 1'b0;
            pend_fail  <= 1'b0;
            pend_idx   <= '0;
            pat_ready  <= 1'b0;
            scan_en    <= 1'b0;
            scan_in    <= 1'b0;
            dut_ce     <= 1'b0;
            dut_pi     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail_count <= '0;
            first_fail <= 16'hFFFF;
            pat_count  <= '0;
        end else begin
            if (finish_fail) begin
                if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
                if (first_fail == 16'hFFFF) first_fail <= pend_idx;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        pat_ready  <= 1'b1;
                        fail_count <= '0;
                        pat_count  <= '0;
                        first_fail <= 16'hFFFF;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        have_prev  <= 1'b0;
                        pend_fail  <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (pat_valid) begin
                        state      <= S_SHIFT;
                        pat_ready  <= 1'b0;
                        scan_en    <= 1'b1;
                        dut_ce     <= 1'b1;
                        scan_in    <= pat_stim[CHAIN_LEN-1];
                        stim_sh    <= pat_stim << 1;
                        cur_exp    <= pat_exp;
                        cur_exp_po <= pat_exp_po;
                        cur_last   <= pat_last;
                        dut_pi     <= pat_pi;
                        k          <= '0;
                    end
                end

                S_SHIFT, S_UNLOAD: begin
                    pend_fail <= k_last ? 1'b0 : (pend_fail || bit_mis);
                    exp_sh    <= exp_sh << 1;
                    if (k_last) begin
                        k       <= '0;
                        scan_en <= 1'b0;
                        scan_in <= 1'b0;
                        if (state == S_SHIFT) begin
                            state <= S_CAPTURE;
                        end else begin
                            state     <= S_DONE;
                            dut_ce    <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            have_prev <= 1'b0;
                        end
                    end else begin
                        k <= k + CW'(1);
                        if (state == S_SHIFT) begin
                            scan_in <= stim_sh[CHAIN_LEN-1];
                            stim_sh <= stim_sh << 1;
                        end
                    end
                end

                S_CAPTURE: begin
                    if (pat_count != 16'hFFFF) pat_count <= pat_count + 16'd1;
                    // The PO result belongs to this pattern; its chain result
                    // arrives during the next shift phase.
                    pend_fail <= (dut_po != cur_exp_po);
                    pend_idx  <= pat_count;
                    exp_sh    <= cur_exp;
                    have_prev <= 1'b1;
                    k         <= '0;
                    if (cur_last) begin
                        state   <= S_UNLOAD;
                        scan_en <= 1'b1;
                        scan_in <= 1'b0;
                    end else begin
                        state     <= S_LOAD;
                        pat_ready <= 1'b1;
                        dut_ce    <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
